mem_req_initiator: RTL and testbench
====================================

Name: mem_req_initiator

Overview:
- Bus-initiator end of the memory request/response protocol that memory-mapped responders such as gpio_interface implement.
- Accepts one load/store command at a time from the pipeline memory stage over a valid/ready handshake, drives a single-cycle request, and waits for the registered response.
- Returns load data zero- or sign-extended, or an error flag.
- Covers misalignment, response-code mismatch and timeout.

Parameters:
TIMEOUT_CYCLES, 15, max WAIT cycles without a response before the command completes with error (1..255)
RETRY_MAX, 2, timeout retries per command; used only when MEM_INIT_RETRY_EN is defined

Ports:
clk  input  1  system clock, all logic on rising edge
aresetn  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command present
o_cmd_ready  output  1  high only in IDLE
i_cmd_addr  input  `ADDR_W  byte address
i_cmd_wr_data  input  `WORD_W  store data, right-justified
i_cmd_wr_en  input  1  1 = store, 0 = load
i_cmd_count  input  `MEM_COUNT_W  `MEM_COUNT_BYTE/HALF/WORD
i_cmd_signed  input  1  sign-extend load result
o_rsp_valid  output  1  one-cycle completion pulse
o_rsp_rd_data  output  `WORD_W  extended load data; 0 for stores and errors
o_rsp_err  output  1  qualifies o_rsp_valid
o_req_addr  output  `ADDR_W  to responder i_req_addr
o_req_wr_data  output  `WORD_W  to responder i_req_wr_data
o_req_wr_en  output  1  to responder i_req_wr_en
o_req_count  output  `MEM_COUNT_W  to responder i_req_count; `MEM_COUNT_NONE when idle
i_res_rd_data  input  `WORD_W  from responder o_res_rd_data, right-justified
i_res_code  input  `MEM_CODE_W  from responder o_res_code

Behaviour:
- Reset: state IDLE; o_cmd_ready=1; o_rsp_valid=0, o_rsp_err=0, o_rsp_rd_data=0; o_req_addr=0, o_req_wr_data=0, o_req_wr_en=0, o_req_count=`MEM_COUNT_NONE; timeout/retry counters 0.
- Reset mid-operation: the in-flight command is dropped, with no o_rsp_valid pulse. Outputs return to reset values asynchronously.
- Response codes (mem_codes.vh): `MEM_CODE_NONE (no response), `MEM_CODE_READ, `MEM_CODE_WRITE, `MEM_CODE_INVALID.
- IDLE:
  - Command latched on valid&&ready.
  - Misaligned (HALF with addr[0]=1; WORD with addr[1:0]!=0) or count=`MEM_COUNT_NONE -> DONE with err=1, no bus activity.
  - Otherwise -> REQ.
- REQ (exactly 1 cycle):
  - o_req_* driven from the latched command; o_req_count = latched count. For loads, o_req_wr_en=0.
  - -> WAIT with timeout counter cleared.
- WAIT:
  - o_req_count=`MEM_COUNT_NONE and o_req_wr_en=0, so a request is never presented twice.
  - i_res_code sampled every cycle. Any non-NONE code -> DONE.
  - err=1 if the code is INVALID, or READ for a store, or WRITE for a load.
  - Counter increments on each WAIT cycle with code NONE. On reaching TIMEOUT_CYCLES -> DONE with err=1.
  - A response on the same cycle the counter reaches the limit wins: no error.
- DONE (1 cycle):
  - o_rsp_valid=1.
  - Load without error: o_rsp_rd_data = i_res_rd_data captured in WAIT, masked to 8/16/32 bits, zero- or sign-extended per i_cmd_signed.
  - WORD ignores i_cmd_signed.
  - -> IDLE.
- Latency: handshake at edge N, request visible in cycle N+1, earliest response sampled at edge N+2, o_rsp_valid high in cycle N+3. Throughput is at most one command per 4 cycles.
- Responses arriving in IDLE/REQ/DONE are ignored.

Optional Feature:
MEM_INIT_RETRY_EN:
- Defined: a timeout in WAIT returns to REQ, re-issuing the identical request, while the retry count < RETRY_MAX. Retry count increments each time; the error is flagged only after RETRY_MAX retries also time out. Retry count clears in IDLE.
- Not defined: the first timeout completes with err=1. RETRY_MAX is unused.

Test Plan:
- Word store 0xdeadbeef to addr 0, responder returns `MEM_CODE_WRITE one cycle after request -> o_req_count=WORD for exactly one cycle; o_rsp_valid at cycle N+3, err=0, rd_data=0.
- Signed byte load, responder returns READ with data 0x00000080 -> rd_data=0xffffff80. Unsigned -> 0x00000080. Unsigned half with 0x1234ffff -> 0x0000ffff.
- Half load at addr 0x3 -> no request issued (o_req_count stays NONE); rsp_valid next-plus-one cycle with err=1.
- Load answered with `MEM_CODE_WRITE, and separately store answered with `MEM_CODE_INVALID -> err=1 for each.
- No response, TIMEOUT_CYCLES=15:
  - Without macro: err=1 after 15 WAIT cycles.
  - With MEM_INIT_RETRY_EN, RETRY_MAX=2: three request pulses, then err=1. Response on the second attempt -> err=0.
- aresetn low during WAIT -> all outputs at reset values immediately, no rsp_valid. A subsequent command completes normally.

Source files
------------

// File: rtl/mem_req_initiator.sv
// mem_req_initiator
//   Bus-initiator side of the memory request/response protocol. It takes one
//   load/store command at a time from the memory stage and presents it to the
//   responder as a single-cycle request. It then waits for the registered
//   response and returns the extended load data, or an error flag.
//
//   Optional feature macro: MEM_INIT_RETRY_EN. When it is defined, a timed-out
//   request is re-issued up to RETRY_MAX times before an error is reported.
//
//   Ports
//     clk, aresetn           clock, asynchronous active-low reset
//     i_cmd_* / o_cmd_ready  command handshake (ready only in IDLE)
//     o_rsp_*                one-cycle completion pulse, data, error
//     o_req_*                request to responder (count NONE when not requesting)
//     i_res_*                registered response from responder
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`define MEM_CODE_NONE 2'd0
`define MEM_CODE_READ 2'd1
`define MEM_CODE_WRITE 2'd2
`define MEM_CODE_INVALID 2'd3
`endif

module mem_req_initiator #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int RETRY_MAX      = 2
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [`ADDR_W-1:0]      i_cmd_addr,
  input  logic [`WORD_W-1:0]      i_cmd_wr_data,
  input  logic                    i_cmd_wr_en,
  input  logic [`MEM_COUNT_W-1:0] i_cmd_count,
  input  logic                    i_cmd_signed,
  output logic                    o_rsp_valid,
  output logic [`WORD_W-1:0]      o_rsp_rd_data,
  output logic                    o_rsp_err,
  output logic [`ADDR_W-1:0]      o_req_addr,
  output logic [`WORD_W-1:0]      o_req_wr_data,
  output logic                    o_req_wr_en,
  output logic [`MEM_COUNT_W-1:0] o_req_count,
  input  logic [`WORD_W-1:0]      i_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_res_code
);

  // Number of re-issues allowed after a timeout; zero when retry is compiled out.
`ifdef MEM_INIT_RETRY_EN
  localparam int EFF_RETRY = RETRY_MAX;
`else
  localparam int EFF_RETRY = RETRY_MAX * 0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                  r_state;
  logic [`ADDR_W-1:0]      r_addr;
  logic [`WORD_W-1:0]      r_wdata;
  logic                    r_wr;
  logic [`MEM_COUNT_W-1:0] r_cnt;
  logic                    r_sgn;
  logic [7:0]              r_tmo;
  logic [7:0]              r_retry;

  logic w_bad_cmd, w_tmo_hit, w_code_err, w_can_retry;

  // Commands that can never be legal on the bus complete without a request.
  assign w_bad_cmd = (i_cmd_count == `MEM_COUNT_NONE) ||
                     ((i_cmd_count == `MEM_COUNT_HALF) && i_cmd_addr[0]) ||
                     ((i_cmd_count == `MEM_COUNT_WORD) && (i_cmd_addr[1:0] != 2'b00));
  assign w_tmo_hit   = ((r_tmo + 8'd1) == TIMEOUT_CYCLES[7:0]);
  assign w_can_retry = (r_retry < EFF_RETRY[7:0]);
  assign w_code_err  = (i_res_code == `MEM_CODE_INVALID) ||
                       ((i_res_code == `MEM_CODE_READ)  &&  r_wr) ||
                       ((i_res_code == `MEM_CODE_WRITE) && !r_wr);

  function automatic logic [`WORD_W-1:0] f_ext(input logic [`WORD_W-1:0] d,
                                               input logic [`MEM_COUNT_W-1:0] c,
                                               input logic s);
    case (c)
      `MEM_COUNT_BYTE: f_ext = {{24{s & d[7]}}, d[7:0]};
      `MEM_COUNT_HALF: f_ext = {{16{s & d[15]}}, d[15:0]};
      default:         f_ext = d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      o_cmd_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rsp_rd_data <= '0;
      o_req_addr    <= '0;
      o_req_wr_data <= '0;
      o_req_wr_en   <= 1'b0;
      o_req_count   <= `MEM_COUNT_NONE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wr          <= 1'b0;
      r_cnt         <= `MEM_COUNT_NONE;
      r_sgn         <= 1'b0;
      r_tmo         <= '0;
      r_retry       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_retry <= '0;
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            r_addr      <= i_cmd_addr;
            r_wdata     <= i_cmd_wr_data;
            r_wr        <= i_cmd_wr_en;
            r_cnt       <= i_cmd_count;
            r_sgn       <= i_cmd_signed;
            if (w_bad_cmd) begin
              r_state       <= S_DONE;
              o_rsp_valid   <= 1'b1;
              o_rsp_err     <= 1'b1;
              o_rsp_rd_data <= '0;
            end else begin
              r_state       <= S_REQ;
              o_req_addr    <= i_cmd_addr;
              o_req_wr_data <= i_cmd_wr_data;
              o_req_wr_en   <= i_cmd_wr_en;
              o_req_count   <= i_cmd_count;
            end
          end
        end
        S_REQ: begin
          // Request is visible for exactly this cycle.
          o_req_count <= `MEM_COUNT_NONE;
          o_req_wr_en <= 1'b0;
          r_tmo       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // A response in the limit cycle takes priority over the timeout.
          if (i_res_code != `MEM_CODE_NONE) begin
            r_state       <= S_DONE;
            o_rsp_valid   <= 1'b1;
            o_rsp_err     <= w_code_err;
            o_rsp_rd_data <= (!w_code_err && !r_wr) ? f_ext(i_res_rd_data, r_cnt, r_sgn) : '0;
          end else if (w_tmo_hit) begin
            if (w_can_retry) begin
              r_retry       <= r_retry + 8'd1;
              r_state       <= S_REQ;
              o_req_addr    <= r_addr;
              o_req_wr_data <= r_wdata;
              o_req_wr_en   <= r_wr;
              o_req_count   <= r_cnt;
            end else begin
              r_state       <= S_DONE;
              o_rsp_valid   <= 1'b1;
              o_rsp_err     <= 1'b1;
              o_rsp_rd_data <= '0;
            end
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        default: begin
          o_rsp_valid   <= 1'b0;
          o_rsp_err     <= 1'b0;
          o_rsp_rd_data <= '0;
          o_cmd_ready   <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator. The bench models the responder inline:
// it answers a chosen request attempt one cycle after that request is seen.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`define MEM_CODE_NONE 2'd0
`define MEM_CODE_READ 2'd1
`define MEM_CODE_WRITE 2'd2
`define MEM_CODE_INVALID 2'd3
`endif

module tb_mem_req_initiator;
  logic clk = 1'b0, aresetn = 1'b0;
  logic i_cmd_valid = 1'b0, o_cmd_ready;
  logic [31:0] i_cmd_addr = '0, i_cmd_wr_data = '0;
  logic i_cmd_wr_en = 1'b0, i_cmd_signed = 1'b0;
  logic [1:0] i_cmd_count = 2'd0;
  logic o_rsp_valid, o_rsp_err, o_req_wr_en;
  logic [31:0] o_rsp_rd_data, o_req_addr, o_req_wr_data;
  logic [1:0] o_req_count;
  logic [31:0] i_res_rd_data = '0;
  logic [1:0] i_res_code = 2'd0;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  mem_req_initiator #(.TIMEOUT_CYCLES(15), .RETRY_MAX(2)) dut (
    .clk(clk), .aresetn(aresetn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wr_data(i_cmd_wr_data),
    .i_cmd_wr_en(i_cmd_wr_en), .i_cmd_count(i_cmd_count), .i_cmd_signed(i_cmd_signed),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rd_data(o_rsp_rd_data), .o_rsp_err(o_rsp_err),
    .o_req_addr(o_req_addr), .o_req_wr_data(o_req_wr_data),
    .o_req_wr_en(o_req_wr_en), .o_req_count(o_req_count),
    .i_res_rd_data(i_res_rd_data), .i_res_code(i_res_code));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge, with the DUT idle.
  // n counts cycles after the handshake edge; n=0 is the request cycle.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic wr, input logic [1:0] cnt, input logic sg,
                     input int resp_attempt, input logic [1:0] code, input logic [31:0] rd,
                     input int exp_lat, input int exp_reqs, input logic exp_err,
                     input logic [31:0] exp_data);
    int n = 0, reqs = 0, since = -1;
    chk({tag, ".ready"}, {31'd0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1'b1; i_cmd_addr = a; i_cmd_wr_data = wd;
    i_cmd_wr_en = wr; i_cmd_count = cnt; i_cmd_signed = sg;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    while (!o_rsp_valid && n < 200) begin
      i_res_code = `MEM_CODE_NONE; i_res_rd_data = 32'h0;
      if (o_req_count != `MEM_COUNT_NONE) begin
        reqs++; since = 0;
        chk({tag, ".req_addr"}, o_req_addr, a);
        chk({tag, ".req_cnt"}, {30'd0, o_req_count}, {30'd0, cnt});
        chk({tag, ".req_wr"}, {31'd0, o_req_wr_en}, {31'd0, wr});
        if (wr) chk({tag, ".req_wd"}, o_req_wr_data, wd);
      end else if (since >= 0) begin
        since++;
        chk({tag, ".wait_wr"}, {31'd0, o_req_wr_en}, 32'd0);
      end
      if (since == 1 && reqs == resp_attempt) begin
        i_res_code = code; i_res_rd_data = rd;
      end
      @(posedge clk); #1; n++;
    end
    i_res_code = `MEM_CODE_NONE; i_res_rd_data = 32'h0;
    chk({tag, ".rsp_valid"}, {31'd0, o_rsp_valid}, 32'd1);
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".req_pulses"}, reqs, exp_reqs);
    chk({tag, ".err"}, {31'd0, o_rsp_err}, {31'd0, exp_err});
    chk({tag, ".data"}, o_rsp_rd_data, exp_data);
    chk({tag, ".done_cnt"}, {30'd0, o_req_count}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".rsp_drop"}, {31'd0, o_rsp_valid}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, o_cmd_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst.ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst.err", {31'd0, o_rsp_err}, 32'd0);
    chk("rst.data", o_rsp_rd_data, 32'd0);
    chk("rst.req_cnt", {30'd0, o_req_count}, 32'd0);
    chk("rst.req_addr", o_req_addr, 32'd0);
    chk("rst.req_wr", {31'd0, o_req_wr_en}, 32'd0);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;

    // Normal transfers: latency 2 after the request cycle (rsp in N+3).
    run("st_word", 32'h0, 32'hdeadbeef, 1, `MEM_COUNT_WORD, 0, 1, `MEM_CODE_WRITE, 32'h0, 2, 1, 0, 32'h0);
    run("ld_sbyte", 32'h5, 32'h0, 0, `MEM_COUNT_BYTE, 1, 1, `MEM_CODE_READ, 32'h00000080, 2, 1, 0, 32'hffffff80);
    run("ld_ubyte", 32'h5, 32'h0, 0, `MEM_COUNT_BYTE, 0, 1, `MEM_CODE_READ, 32'h00000080, 2, 1, 0, 32'h00000080);
    run("ld_uhalf", 32'h2, 32'h0, 0, `MEM_COUNT_HALF, 0, 1, `MEM_CODE_READ, 32'h1234ffff, 2, 1, 0, 32'h0000ffff);
    run("ld_shalf", 32'h2, 32'h0, 0, `MEM_COUNT_HALF, 1, 1, `MEM_CODE_READ, 32'h1234ffff, 2, 1, 0, 32'hffffffff);
    run("ld_sword", 32'h8, 32'h0, 0, `MEM_COUNT_WORD, 1, 1, `MEM_CODE_READ, 32'h80000001, 2, 1, 0, 32'h80000001);

    // Commands rejected before any bus activity.
    run("mis_half", 32'h3, 32'h0, 0, `MEM_COUNT_HALF, 0, 0, `MEM_CODE_NONE, 32'h0, 0, 0, 1, 32'h0);
    run("mis_word", 32'h2, 32'h0, 0, `MEM_COUNT_WORD, 0, 0, `MEM_CODE_NONE, 32'h0, 0, 0, 1, 32'h0);
    run("cnt_none", 32'h0, 32'h0, 1, `MEM_COUNT_NONE, 0, 0, `MEM_CODE_NONE, 32'h0, 0, 0, 1, 32'h0);

    // Response-code mismatches.
    run("ld_wrcode", 32'h4, 32'h0, 0, `MEM_COUNT_WORD, 0, 1, `MEM_CODE_WRITE, 32'h55aa55aa, 2, 1, 1, 32'h0);
    run("st_inval", 32'h4, 32'h12345678, 1, `MEM_COUNT_WORD, 0, 1, `MEM_CODE_INVALID, 32'h0, 2, 1, 1, 32'h0);
    run("st_rdcode", 32'h6, 32'h0000abcd, 1, `MEM_COUNT_HALF, 0, 1, `MEM_CODE_READ, 32'h0, 2, 1, 1, 32'h0);

    // Timeouts: each attempt is 1 REQ cycle + 15 WAIT cycles.
`ifdef MEM_INIT_RETRY_EN
    run("tmo", 32'hc, 32'h0, 0, `MEM_COUNT_WORD, 0, 0, `MEM_CODE_NONE, 32'h0, 48, 3, 1, 32'h0);
    run("retry_ok", 32'hc, 32'h0, 0, `MEM_COUNT_BYTE, 1, 2, `MEM_CODE_READ, 32'h000000ff, 18, 2, 0, 32'hffffffff);
`else
    run("tmo", 32'hc, 32'h0, 0, `MEM_COUNT_WORD, 0, 0, `MEM_CODE_NONE, 32'h0, 16, 1, 1, 32'h0);
    run("retry_ok", 32'hc, 32'h0, 0, `MEM_COUNT_BYTE, 1, 2, `MEM_CODE_READ, 32'h000000ff, 16, 1, 1, 32'h0);
`endif

    // Reset while waiting: outputs clear at once, no completion pulse.
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h10; i_cmd_wr_data = 32'hcafef00d;
    i_cmd_wr_en = 1'b1; i_cmd_count = `MEM_COUNT_WORD; i_cmd_signed = 1'b0;
    @(posedge clk); #1; i_cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2; aresetn = 1'b0; #1;
    chk("arst.ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("arst.req_addr", o_req_addr, 32'd0);
    chk("arst.req_wd", o_req_wr_data, 32'd0);
    chk("arst.req_cnt", {30'd0, o_req_count}, 32'd0);
    @(posedge clk); #1;
    chk("arst.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    run("post_rst", 32'h10, 32'h0, 0, `MEM_COUNT_HALF, 1, 1, `MEM_CODE_READ, 32'h00008001, 2, 1, 0, 32'hffff8001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
